word_byte_serializer: RTL

Splits a 32-bit word into a stream of 8-bit bytes on a valid/ready byte bus. It is the send-side counterpart of the data register, which assembles bytes into 32-bit words. It sits between the ALU-system word datapath (register or ALU output) and any 8-bit sink: memory write port, byte bus, or another data register's input. Byte order and byte count are selectable per word, so that a sink using shift-left (MSB-first) or shift-right (LSB-first) assembly rebuilds the original value.

---
 rtl/word_byte_pkg.sv | 31 +++
 rtl/word_byte_serializer.sv | 96 +++++++++
 2 files changed

// File: rtl/word_byte_pkg.sv
// Shared types and constants for the word-to-byte serializer.
package word_byte_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  // Byte order, sampled with Load
  localparam logic ORDER_MSB = 1'b0;
  localparam logic ORDER_LSB = 1'b1;

  // Len encodes byte count minus one
  localparam logic [1:0] LEN_1B = 2'd0;
  localparam logic [1:0] LEN_2B = 2'd1;
  localparam logic [1:0] LEN_3B = 2'd2;
  localparam logic [1:0] LEN_4B = 2'd3;

  // Pick byte idx of a 32-bit word (idx 0 = word[7:0])
  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] idx);
    logic [7:0] b;
    unique case (idx)
      2'd0: b = word[7:0];
      2'd1: b = word[15:8];
      2'd2: b = word[23:16];
      2'd3: b = word[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/word_byte_serializer.sv
// Serializes a latched 32-bit word into 1..4 bytes on a valid/ready byte bus,
// MSB-first or LSB-first. All outputs decode from registers only.
module word_byte_serializer
  import word_byte_pkg::*;
(
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic [31:0] I,
  input  logic        Load,
  input  logic        Order,
  input  logic [1:0]  Len,
  input  logic        Abort,
  output logic        InReady,
  output logic [7:0]  O,
  output logic        OValid,
  input  logic        OReady,
  output logic [1:0]  ByteIdx,
  output logic        Last
);

  state_e      state_q, state_d;
  logic [31:0] word_q;
  logic        order_q;
  logic [1:0]  len_q;
  logic [1:0]  idx_q;
  logic [1:0]  final_idx;
  logic        at_last;

  // MSB-first walks down to byte 0; LSB-first walks up to byte Len
  assign final_idx = (order_q == ORDER_MSB) ? 2'd0 : len_q;
  assign at_last   = (idx_q == final_idx);

  // State register
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; Abort beats both Load and the output handshake
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!Abort && Load) state_d = SEND;
      end
      SEND: begin
        if (Abort) begin
          state_d = IDLE;
        end else if (OReady && at_last) begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // Word capture and byte index counter
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      word_q  <= 32'h0;
      order_q <= ORDER_MSB;
      len_q   <= LEN_1B;
      idx_q   <= 2'd0;
    end else if (Abort) begin
      word_q <= 32'h0;
      idx_q  <= 2'd0;
    end else if (state_q == IDLE) begin
      if (Load) begin
        word_q  <= I;
        order_q <= Order;
        len_q   <= Len;
        idx_q   <= (Order == ORDER_MSB) ? Len : 2'd0;
      end
    end else if (OReady) begin
      if (at_last) begin
        idx_q <= 2'd0;
      end else if (order_q == ORDER_MSB) begin
        idx_q <= idx_q - 2'd1;
      end else begin
        idx_q <= idx_q + 2'd1;
      end
    end
  end

  // Outputs decoded from state and datapath registers
  always_comb begin
    InReady = (state_q == IDLE);
    OValid  = (state_q == SEND);
    O       = (state_q == SEND) ? byte_sel(word_q, idx_q) : 8'h00;
    ByteIdx = idx_q;
    Last    = (state_q == SEND) && at_last;
  end

endmodule
